// File: rtl/axis_upsizer_pkg.sv
// Shared types and helpers for the AXI-Stream width upsizer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package axis_upsizer_pkg;

    // Packing state: EMPTY means no lanes held, FILL means 1..RATIO-1 lanes held.
    typedef enum logic {
        EMPTY = 1'b0,
        FILL  = 1'b1
    } fill_state_t;

    // Default packing ratio and the matching lane-index type.
    localparam int DEF_RATIO  = 4;
    localparam int LANE_CNT_W = $clog2(DEF_RATIO);
    typedef logic [LANE_CNT_W-1:0] lane_idx_t;

    // Lane counter width for an arbitrary ratio (at least one bit).
    function automatic int lane_cnt_w(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Output register slice holding the wide word presented to the downstream slave.
// Latency: one cycle from load to m_tvalid.
// Backpressure: holds m_tdata/m_tlast stable until drained; load takes priority over drain.
module axis_out_reg
    import axis_upsizer_pkg::*;
#(
    parameter int DATA_W = 32
`ifdef AXIS_UPSIZER_TKEEP_EN
    ,
    parameter int KEEP_W = 4
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              drain,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
`ifdef AXIS_UPSIZER_TKEEP_EN
    input  logic [KEEP_W-1:0] load_keep,
    output logic [KEEP_W-1:0] m_tkeep,
`endif
    output logic              m_tvalid,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast
);

    // Reload on a closing accept, otherwise drop valid once the word has transferred.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tlast  <= 1'b0;
`ifdef AXIS_UPSIZER_TKEEP_EN
            m_tkeep  <= '0;
`endif
        end else if (load) begin
            m_tvalid <= 1'b1;
            m_tdata  <= load_data;
            m_tlast  <= load_last;
`ifdef AXIS_UPSIZER_TKEEP_EN
            m_tkeep  <= load_keep;
`endif
        end else if (drain) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_upsizer.sv
// AXI-Stream upsizer: packs RATIO narrow beats into one wide word (lane 0 first) or bypasses per beat.
// Latency: closing beat appears on m_* one cycle after its accept; full rate with m_tready held high.
// Backpressure: s_tready = !m_tvalid || m_tready; optional m_tkeep under AXIS_UPSIZER_TKEEP_EN.
module axis_upsizer
    import axis_upsizer_pkg::*;
#(
    parameter  int S_DATA_W = 8,
    parameter  int RATIO    = 4,
    localparam int M_DATA_W = S_DATA_W * RATIO
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  upsizing,
    input  logic                  s_tvalid,
    input  logic [S_DATA_W-1:0]   s_tdata,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic                  m_tvalid,
    output logic [M_DATA_W-1:0]   m_tdata,
    output logic                  m_tlast,
`ifdef AXIS_UPSIZER_TKEEP_EN
    output logic [M_DATA_W/8-1:0] m_tkeep,
`endif
    input  logic                  m_tready
);

    localparam int LW = lane_cnt_w(RATIO);
    typedef logic [LW-1:0] lane_t;

`ifdef AXIS_UPSIZER_TKEEP_EN
    localparam int KEEP_W  = M_DATA_W / 8;
    localparam int LANE_KB = S_DATA_W / 8;
    logic [KEEP_W-1:0] keep_nxt;
`endif

    fill_state_t         state;
    lane_t               lane_cnt;
    logic [M_DATA_W-1:0] acc;
    logic                mode_q;
    logic                eff_mode;
    logic                accept;
    logic                closes;
    logic                drain;
    logic [M_DATA_W-1:0] word_nxt;

    assign s_tready = !m_tvalid || m_tready;
    assign accept   = s_tvalid && s_tready;
    assign drain    = m_tvalid && m_tready;
    // Mode is sampled live only for the first lane of a word; afterwards the latched copy rules.
    assign eff_mode = (state == EMPTY) ? upsizing : mode_q;
    assign closes   = (lane_cnt == lane_t'(RATIO - 1)) || s_tlast || !eff_mode;

    // Merge the incoming beat into lane lane_cnt; lanes above it are still zero in the accumulator.
    always_comb begin
        word_nxt = acc;
`ifdef AXIS_UPSIZER_TKEEP_EN
        keep_nxt = '0;
`endif
        for (int i = 0; i < RATIO; i++) begin
            if (lane_t'(i) == lane_cnt) begin
                word_nxt[i*S_DATA_W +: S_DATA_W] = s_tdata;
            end
`ifdef AXIS_UPSIZER_TKEEP_EN
            if (lane_t'(i) <= lane_cnt) begin
                keep_nxt[i*LANE_KB +: LANE_KB] = '1;
            end
`endif
        end
    end

    // Packing FSM: accumulate lanes until the word closes, then start over from lane 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            lane_cnt <= '0;
            acc      <= '0;
            mode_q   <= 1'b0;
        end else if (accept) begin
            if (state == EMPTY) begin
                mode_q <= upsizing;
            end
            if (closes) begin
                acc      <= '0;
                lane_cnt <= '0;
                state    <= EMPTY;
            end else begin
                acc      <= word_nxt;
                lane_cnt <= lane_cnt + lane_t'(1);
                state    <= FILL;
            end
        end
    end

    axis_out_reg #(
        .DATA_W    (M_DATA_W)
`ifdef AXIS_UPSIZER_TKEEP_EN
        ,
        .KEEP_W    (KEEP_W)
`endif
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (accept && closes),
        .drain     (drain),
        .load_data (word_nxt),
        .load_last (s_tlast),
`ifdef AXIS_UPSIZER_TKEEP_EN
        .load_keep (keep_nxt),
        .m_tkeep   (m_tkeep),
`endif
        .m_tvalid  (m_tvalid),
        .m_tdata   (m_tdata),
        .m_tlast   (m_tlast)
    );

endmodule
